mux2to1_reg: RTL and testbench
==============================

Name: mux2to1_reg

Overview:
Parameterised 2-input, 1-output data selector with registered output, input-valid tracking and a select-switch event counter. Drop-in selector for datapath steering where a clean, glitch-free, reset-defined output is required. Combinational selection: in0 when sel=0, in1 when sel=1. Result is captured on the clock.

Parameters:
- WIDTH, 1, bit width of in0, in1 and out.
- CNT_WIDTH, 16, width of the select-switch counter.
- REGISTER_OUT, 1, 1 = out registered (1-cycle latency); 0 = out combinational (0 latency; out_valid still registered).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in0  input  WIDTH  data selected when sel=0.
- in1  input  WIDTH  data selected when sel=1.
- sel  input  1  select: 0 -> in0, 1 -> in1.
- in_valid  input  1  qualifies in0/in1/sel this cycle.
- cnt_clr  input  1  synchronous clear of switch_cnt.
- out  output  WIDTH  selected data.
- out_valid  output  1  out holds a result from a valid input.
- switch_cnt  output  CNT_WIDTH  number of accepted sel value changes, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): out=0 when REGISTER_OUT=1, out_valid=0, switch_cnt=0, internal last_sel=0, last_sel_valid=0.
- Selection function: mux = sel ? in1 : in0, bitwise across WIDTH. A sel of X/Z does not occur by requirement; no special handling.
- REGISTER_OUT=1:
  - On each rising clk with in_valid=1: out <= mux; out_valid <= 1.
  - With in_valid=0: out holds its previous value; out_valid <= 0.
- REGISTER_OUT=0:
  - out = mux continuously, independent of in_valid and clock.
  - out_valid is registered exactly as above.
- Switch counter:
  - On a valid cycle where last_sel_valid=1 and sel != last_sel: switch_cnt increments by 1.
  - Saturates at all-ones; no wrap.
  - On every valid cycle: last_sel <= sel and last_sel_valid <= 1. The first valid cycle after reset never counts.
- cnt_clr=1 sets switch_cnt <= 0 on that edge and has priority over an increment in the same cycle. It does not affect last_sel or last_sel_valid.
- Reset asserted mid-stream clears all state on assertion. The first valid cycle after release behaves as the first after power-up.
- No backpressure: the block accepts every valid cycle.

Test Plan:
- Reset: rst_n=0 with in0=1, in1=1, sel=1 -> out=0, out_valid=0, switch_cnt=0 immediately, without a clock edge.
- Truth table, WIDTH=1, sel=0, in_valid=1: (in0,in1)=00,01,10,11 -> out=0,0,1,1 one cycle later. Then sel=1 with the same sequence -> out=0,1,0,1. out_valid=1 throughout.
- Hold: in_valid=0 while in0/in1/sel toggle -> out unchanged, out_valid=0 next cycle.
- Switch counting: valid sel sequence 0,0,1,1,0,1 -> switch_cnt=3.
  - cnt_clr asserted together with a toggle -> switch_cnt=0.
  - CNT_WIDTH=2 with 5 toggles -> switch_cnt saturates at 3.
- Wide/combinational: WIDTH=8, REGISTER_OUT=0, in0=0xA5, in1=0x3C -> out=0xA5 with sel=0 and 0x3C with sel=1, same delta cycle.
- Reset mid-operation: assert rst_n=0 after 2 counted toggles -> switch_cnt=0. After release, the first valid sel=1 does not count.

Source files
------------

// File: rtl/mux2to1_reg_if.sv
// Bus bundle for mux2to1_reg: selector inputs, qualifiers and the result/status outputs.
// master drives data and select; slave is the selector itself.
interface mux2to1_reg_if #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
);

  logic [WIDTH-1:0]     in0;
  logic [WIDTH-1:0]     in1;
  logic                 sel;
  logic                 in_valid;
  logic                 cnt_clr;
  logic [WIDTH-1:0]     out;
  logic                 out_valid;
  logic [CNT_WIDTH-1:0] switch_cnt;

  modport master (
    output in0,
    output in1,
    output sel,
    output in_valid,
    output cnt_clr,
    input  out,
    input  out_valid,
    input  switch_cnt
  );

  modport slave (
    input  in0,
    input  in1,
    input  sel,
    input  in_valid,
    input  cnt_clr,
    output out,
    output out_valid,
    output switch_cnt
  );

endinterface

// File: rtl/mux2to1_reg.sv
// Parameterised 2:1 data selector with optional output register, valid tracking
// and a saturating counter of accepted select changes.
module mux2to1_reg #(
  parameter int WIDTH        = 1,
  parameter int CNT_WIDTH    = 16,
  parameter bit REGISTER_OUT = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mux2to1_reg_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [WIDTH-1:0]     mux_sel;

  logic                 out_valid_q;
  logic                 out_valid_d;
  logic                 last_sel_q;
  logic                 last_sel_d;
  logic                 last_sel_valid_q;
  logic                 last_sel_valid_d;
  logic [CNT_WIDTH-1:0] switch_cnt_q;
  logic [CNT_WIDTH-1:0] switch_cnt_d;
  logic                 switch_hit;

  assign mux_sel = bus.sel ? bus.in1 : bus.in0;

  // A change only counts against a select value that was itself accepted.
  assign switch_hit = bus.in_valid && last_sel_valid_q && (bus.sel != last_sel_q);

  always_comb begin
    out_valid_d      = bus.in_valid;
    last_sel_d       = last_sel_q;
    last_sel_valid_d = last_sel_valid_q;
    switch_cnt_d     = switch_cnt_q;

    if (bus.in_valid) begin
      last_sel_d       = bus.sel;
      last_sel_valid_d = 1'b1;
    end

    if (bus.cnt_clr) begin
      switch_cnt_d = '0;
    end else if (switch_hit && (switch_cnt_q != CNT_MAX)) begin
      switch_cnt_d = switch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      last_sel_q       <= 1'b0;
      last_sel_valid_q <= 1'b0;
      switch_cnt_q     <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      last_sel_q       <= last_sel_d;
      last_sel_valid_q <= last_sel_valid_d;
      switch_cnt_q     <= switch_cnt_d;
    end
  end

  generate
    if (REGISTER_OUT) begin : g_reg_out
      logic [WIDTH-1:0] out_q;
      logic [WIDTH-1:0] out_d;

      always_comb begin
        out_d = out_q;
        if (bus.in_valid) begin
          out_d = mux_sel;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign bus.out = out_q;
    end else begin : g_comb_out
      // Unregistered mode follows the inputs directly; out_valid stays registered.
      assign bus.out = mux_sel;
    end
  endgenerate

  assign bus.out_valid  = out_valid_q;
  assign bus.switch_cnt = switch_cnt_q;

endmodule

// File: tb/tb_mux2to1_reg.sv
// Self-checking bench for mux2to1_reg: registered 1-bit selector, a 2-bit counter
// variant for saturation, and an 8-bit combinational variant.
module tb_mux2to1_reg;

   // Expected registered results for the two 1-bit instances.
   typedef struct {
      logic        out;
      logic        outValid;
      logic [15:0] cntA;
      logic [1:0]  cntS;
   } expT;

   logic clk;
   logic rst_n;

   int cmpCount;
   int errCount;

   expT        sbQ[$];
   logic [7:0] combQ[$];

   // Reference model of the selector state
   logic        mOut;
   logic        mLastSel;
   logic        mLastValid;
   logic [15:0] mCntA;
   logic [1:0]  mCntS;

   mux2to1_reg_if #(.WIDTH(1), .CNT_WIDTH(16)) aIf ();
   mux2to1_reg_if #(.WIDTH(1), .CNT_WIDTH(2))  sIf ();
   mux2to1_reg_if #(.WIDTH(8), .CNT_WIDTH(16)) cIf ();

   mux2to1_reg #(.WIDTH(1), .CNT_WIDTH(16), .REGISTER_OUT(1'b1)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (aIf.slave)
   );

   mux2to1_reg #(.WIDTH(1), .CNT_WIDTH(2), .REGISTER_OUT(1'b1)) dutS (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sIf.slave)
   );

   mux2to1_reg #(.WIDTH(8), .CNT_WIDTH(16), .REGISTER_OUT(1'b0)) dutC (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (cIf.slave)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      cmpCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, actual, expected);
      end
   endtask

   // Clear the reference model the way an asynchronous reset clears the DUT
   task automatic resetModel();
      mOut       = 1'b0;
      mLastSel   = 1'b0;
      mLastValid = 1'b0;
      mCntA      = '0;
      mCntS      = '0;
   endtask

   // Drive one cycle into both 1-bit instances, predict, then compare after the edge
   task automatic applyStimulus(input string tag, input logic i0, input logic i1,
                                input logic s, input logic v, input logic clr);
      expT e;
      logic toggled;
      aIf.in0 = i0; aIf.in1 = i1; aIf.sel = s; aIf.in_valid = v; aIf.cnt_clr = clr;
      sIf.in0 = i0; sIf.in1 = i1; sIf.sel = s; sIf.in_valid = v; sIf.cnt_clr = clr;

      toggled = v && mLastValid && (s != mLastSel);
      if (clr) begin
         mCntA = '0;
         mCntS = '0;
      end else if (toggled) begin
         if (mCntA != 16'hFFFF) mCntA = mCntA + 16'd1;
         if (mCntS != 2'b11)    mCntS = mCntS + 2'd1;
      end
      if (v) begin
         mOut       = s ? i1 : i0;
         mLastSel   = s;
         mLastValid = 1'b1;
      end
      e.out      = mOut;
      e.outValid = v;
      e.cntA     = mCntA;
      e.cntS     = mCntS;
      sbQ.push_back(e);

      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      checkOutput($sformatf("%s.out", tag),       32'(aIf.out),        32'(e.out));
      checkOutput($sformatf("%s.out_valid", tag), 32'(aIf.out_valid),  32'(e.outValid));
      checkOutput($sformatf("%s.cnt", tag),       32'(aIf.switch_cnt), 32'(e.cntA));
      checkOutput($sformatf("%s.cnt2", tag),      32'(sIf.switch_cnt), 32'(e.cntS));
   endtask

   // Drive the combinational instance and compare without any clock edge
   task automatic applyComb(input string tag, input logic [7:0] i0, input logic [7:0] i1,
                            input logic s);
      cIf.in0 = i0;
      cIf.in1 = i1;
      cIf.sel = s;
      combQ.push_back(s ? i1 : i0);
      #1;
      checkOutput(tag, 32'(cIf.out), 32'(combQ.pop_front()));
   endtask

   // Main test sequence
   initial begin
      cmpCount = 0;
      errCount = 0;
      resetModel();

      rst_n = 1'b1;
      aIf.in0 = 1'b1; aIf.in1 = 1'b1; aIf.sel = 1'b1; aIf.in_valid = 1'b1; aIf.cnt_clr = 1'b0;
      sIf.in0 = 1'b1; sIf.in1 = 1'b1; sIf.sel = 1'b1; sIf.in_valid = 1'b1; sIf.cnt_clr = 1'b0;
      cIf.in0 = 8'h00; cIf.in1 = 8'h00; cIf.sel = 1'b0; cIf.in_valid = 1'b0; cIf.cnt_clr = 1'b0;

      // Reset takes effect before any clock edge
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst.out",        32'(aIf.out),        32'd0);
      checkOutput("rst.out_valid",  32'(aIf.out_valid),  32'd0);
      checkOutput("rst.cnt",        32'(aIf.switch_cnt), 32'd0);
      checkOutput("rst.cnt2",       32'(sIf.switch_cnt), 32'd0);
      checkOutput("rst.c_valid",    32'(cIf.out_valid),  32'd0);
      @(posedge clk);
      #1;
      checkOutput("rst_hold.out",   32'(aIf.out),        32'd0);
      checkOutput("rst_hold.valid", 32'(aIf.out_valid),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Truth table, sel=0 then sel=1; a single select change overall
      for (int s = 0; s < 2; s++) begin
         for (int p = 0; p < 4; p++) begin
            logic [1:0] pat;
            pat = 2'(p);
            applyStimulus($sformatf("tt_s%0d_p%0d", s, p), pat[1], pat[0], 1'(s), 1'b1, 1'b0);
         end
      end

      // Hold: invalid cycles must not disturb out
      applyStimulus("hold0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus("hold1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("hold2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Clear on a toggling cycle, then sequence 0,1,1,0,1 gives three switches
      applyStimulus("clr_tog", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus("sw1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("sw2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus("sw3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus("sw4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus("sw5", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("sw_total", 32'(aIf.switch_cnt), 32'd3);

      // Clear together with a toggle wins over the increment
      applyStimulus("clr_pri", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("clr_pri_zero", 32'(aIf.switch_cnt), 32'd0);

      // Five toggles: wide counter reaches 5, 2-bit counter sticks at 3
      for (int k = 0; k < 5; k++) begin
         applyStimulus($sformatf("sat%0d", k), 1'b0, 1'b1, 1'(~k[0]), 1'b1, 1'b0);
      end
      checkOutput("sat_wide", 32'(aIf.switch_cnt), 32'd5);
      checkOutput("sat_2bit", 32'(sIf.switch_cnt), 32'd3);

      // Two counted toggles with out=1, then reset between clock edges
      applyStimulus("pre_clr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus("pre_t1",  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus("pre_t2",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      resetModel();
      checkOutput("mid_rst.out",   32'(aIf.out),        32'd0);
      checkOutput("mid_rst.valid", 32'(aIf.out_valid),  32'd0);
      checkOutput("mid_rst.cnt",   32'(aIf.switch_cnt), 32'd0);
      checkOutput("mid_rst.cnt2",  32'(sIf.switch_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("post_first", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("post_first_nocount", 32'(aIf.switch_cnt), 32'd0);
      applyStimulus("post_second", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

      // Combinational 8-bit instance follows sel with no clock
      applyComb("comb_sel0", 8'hA5, 8'h3C, 1'b0);
      applyComb("comb_sel1", 8'hA5, 8'h3C, 1'b1);
      applyComb("comb_sel0b", 8'h5A, 8'hC3, 1'b0);
      checkOutput("comb_valid_idle", 32'(cIf.out_valid), 32'd0);
      cIf.in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("comb_valid_set", 32'(cIf.out_valid), 32'd1);
      cIf.in_valid = 1'b0;
      applyComb("comb_invalid", 8'h5A, 8'hC3, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("comb_valid_clr", 32'(cIf.out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
